// File: rtl/mul_engine.sv
// ============================================================================
// Module      : mul_engine
// Description : Iterative shift-add multiplier, started by a rising edge on
//               ctrl_enable; one partial product per cycle over OP_W cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_engine #(
    parameter int OP_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ctrl_enable,
    input  logic [31:0] data_in,
    output logic        status_busy,
    output logic [31:0] ip_data_out,
    output logic        done_pulse
);

    localparam int PROD_W = 2 * OP_W;
    localparam int CNT_W  = $clog2(OP_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OP_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                en_q, en_d;
    logic [PROD_W-1:0]   a_q, a_d;
    logic [OP_W-1:0]     b_q, b_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         dout_q, dout_d;
    logic                done_q, done_d;

    logic                start;
    logic [PROD_W-1:0]   acc_sum;
    logic                w_unused_data;

    // Bits above 2*OP_W are not operands when OP_W < 16.
    assign w_unused_data = ^data_in;

    assign start   = ctrl_enable & ~en_q;
    assign acc_sum = b_q[0] ? (acc_q + a_q) : acc_q;

    always_comb begin
        en_d    = ctrl_enable;
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!ctrl_enable) begin
                    state_d = ST_IDLE;
                end else begin
                    a_d     = {{OP_W{1'b0}}, data_in[OP_W-1:0]};
                    b_d     = data_in[PROD_W-1:OP_W];
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A dropped enable wins over a completion in the same cycle.
                if (!ctrl_enable) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = acc_sum;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        dout_d  = 32'(acc_sum);
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
        end
    end

    assign status_busy = (state_q != ST_IDLE);
    assign ip_data_out = dout_q;
    assign done_pulse  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_engine.sv
// ============================================================================
// Module      : tb_mul_engine
// Description : Self-checking bench for mul_engine against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_engine;

    localparam int OP_W = 16;

    logic        clk;
    logic        rst;
    logic        ctrl_enable;
    logic [31:0] data_in;
    logic        status_busy;
    logic [31:0] ip_data_out;
    logic        done_pulse;

    int          total;
    int          bad;
    logic [31:0] last_out;

    mul_engine #(.OP_W(OP_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .ctrl_enable (ctrl_enable),
        .data_in     (data_in),
        .status_busy (status_busy),
        .ip_data_out (ip_data_out),
        .done_pulse  (done_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [31:0] d);
        longint unsigned mask, a, b;
        mask = (64'd1 << OP_W) - 64'd1;
        a    = longint'(d) & mask;
        b    = (longint'(d) >> OP_W) & mask;
        return 32'(a * b);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a multiply from a clean 0->1 edge and observes a fixed window.
    task automatic do_mul(input logic [31:0] d, input bit chg, input logic [31:0] d2, input string nm);
        int          busy_n, done_n;
        bit          done_bad, hold_bad;
        logic [31:0] exp;
        exp      = model(d);
        busy_n   = 0;
        done_n   = 0;
        done_bad = 1'b0;
        hold_bad = 1'b0;
        ctrl_enable = 1'b0;
        step();
        data_in     = d;
        ctrl_enable = 1'b1;
        for (int i = 0; i < 25; i++) begin
            step();
            if (chg && i == 5) data_in = d2;
            if (status_busy === 1'b1) begin
                busy_n++;
                if (ip_data_out !== last_out) hold_bad = 1'b1;
            end
            if (done_pulse === 1'b1) begin
                done_n++;
                if (status_busy !== 1'b0 || ip_data_out !== exp) done_bad = 1'b1;
            end
        end
        total++;
        if (busy_n !== OP_W + 1) begin
            bad++;
            $display("FAIL %s busy_cycles got=%0d want=%0d", nm, busy_n, OP_W + 1);
        end
        total++;
        if (done_n !== 1) begin
            bad++;
            $display("FAIL %s done_count got=%0d want=1", nm, done_n);
        end
        total++;
        if (done_bad !== 1'b0) begin
            bad++;
            $display("FAIL %s done_alignment got=%0b want=0", nm, done_bad);
        end
        total++;
        if (hold_bad !== 1'b0) begin
            bad++;
            $display("FAIL %s out_changed_while_busy got=%0b want=0", nm, hold_bad);
        end
        total++;
        if (ip_data_out !== exp) begin
            bad++;
            $display("FAIL %s product got=%h want=%h", nm, ip_data_out, exp);
        end
        last_out = exp;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        ctrl_enable = 1'b0;
        data_in     = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (status_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy got=%b want=0", status_busy);
        end
        total++;
        if (ip_data_out !== 32'h0) begin
            bad++;
            $display("FAIL reset_out got=%h want=00000000", ip_data_out);
        end
        total++;
        if (done_pulse !== 1'b0) begin
            bad++;
            $display("FAIL reset_done got=%b want=0", done_pulse);
        end
        @(negedge clk);
        rst      = 1'b0;
        last_out = 32'h0;
        step();
    endtask

    task automatic test_directed();
        do_mul(32'h0003_0005, 1'b0, 32'h0, "dir_3x5");
        do_mul(32'hFFFF_FFFF, 1'b0, 32'h0, "dir_max");
        do_mul(32'h0000_1234, 1'b0, 32'h0, "dir_b_zero");
        do_mul(32'h1234_0000, 1'b0, 32'h0, "dir_a_zero");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            do_mul($urandom, 1'b0, 32'h0, $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_abort();
        int done_n;
        do_mul(32'h0003_0005, 1'b0, 32'h0, "abort_pre");
        ctrl_enable = 1'b0;
        step();
        data_in     = 32'h0002_0007;
        ctrl_enable = 1'b1;
        step();
        total++;
        if (status_busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_busy_rise got=%b want=1", status_busy);
        end
        repeat (6) step();
        ctrl_enable = 1'b0;
        step();
        total++;
        if (status_busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_busy_fall got=%b want=0", status_busy);
        end
        done_n = (done_pulse === 1'b1) ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done_pulse === 1'b1) done_n++;
        end
        total++;
        if (done_n !== 0) begin
            bad++;
            $display("FAIL abort_no_done got=%0d want=0", done_n);
        end
        total++;
        if (ip_data_out !== 32'h0000_000F) begin
            bad++;
            $display("FAIL abort_out_kept got=%h want=0000000f", ip_data_out);
        end
    endtask

    task automatic test_hold_and_restart();
        int busy_n;
        do_mul(32'h0011_0022, 1'b0, 32'h0, "hold_first");
        busy_n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (status_busy === 1'b1) busy_n++;
        end
        total++;
        if (busy_n !== 0) begin
            bad++;
            $display("FAIL hold_no_restart busy_cycles got=%0d want=0", busy_n);
        end
        do_mul(32'h00AB_00CD, 1'b1, 32'hFFFF_FFFF, "restart_data_change");
    endtask

    task automatic test_reset_mid();
        int busy_n, done_n;
        ctrl_enable = 1'b0;
        step();
        data_in     = 32'h0009_000B;
        ctrl_enable = 1'b1;
        repeat (8) step();
        #2 rst = 1'b1;
        #1;
        total++;
        if (status_busy !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_busy got=%b want=0", status_busy);
        end
        total++;
        if (ip_data_out !== 32'h0) begin
            bad++;
            $display("FAIL rstmid_out got=%h want=00000000", ip_data_out);
        end
        total++;
        if (done_pulse !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_done got=%b want=0", done_pulse);
        end
        @(negedge clk);
        rst      = 1'b0;
        last_out = 32'h0;
        step();
        total++;
        if (status_busy !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_restart got=%b want=1", status_busy);
        end
        busy_n = 1;
        done_n = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (status_busy === 1'b1) busy_n++;
            if (done_pulse === 1'b1) done_n++;
        end
        total++;
        if (busy_n !== OP_W + 1 || done_n !== 1) begin
            bad++;
            $display("FAIL rstmid_run busy=%0d done=%0d want busy=%0d done=1", busy_n, done_n, OP_W + 1);
        end
        total++;
        if (ip_data_out !== model(32'h0009_000B)) begin
            bad++;
            $display("FAIL rstmid_product got=%h want=%h", ip_data_out, model(32'h0009_000B));
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_directed();
        test_random();
        test_abort();
        test_hold_and_restart();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mul_engine.md
# mul_engine

Iterative shift-add multiplier that is the custom IP behind the register block: consumes `ctrl_enable` and `data_in`, produces `status_busy` and `ip_data_out`. A rising edge on `ctrl_enable` starts one multiply of the two operand halves of `data_in`. The result appears on `ip_data_out` after OP_W shift-add iterations. Software polls STATUS until busy clears, then reads DATA_OUT.

## Interface
- `OP_W`, default 16: operand width in bits, legal 1..16.
  - Operand A = `data_in[OP_W-1:0]`.
  - Operand B = `data_in[2*OP_W-1:OP_W]`.
  - Iteration count = OP_W.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `ctrl_enable`  in  1: CTRL.enable level from the register block; its 0→1 edge is the start request.
- `data_in`  in  32: operand register from the register block.
- `status_busy`  out  1: high while a multiply is in progress.
- `ip_data_out`  out  32: last completed product, zero-extended to 32 bits.
- `done_pulse`  out  1: one-cycle pulse on completion, for interrupt/trace use.

## Operation
- Registered `en_q` samples `ctrl_enable` every cycle.
  - `start = ctrl_enable & ~en_q`.
- FSM states:
  - IDLE:
    - `start` → LOAD.
    - Otherwise stay.
  - LOAD:
    - Capture `a_reg` = A, zero-extended to 2*OP_W bits.
    - Capture `b_reg` = B.
    - Clear `acc` and `cnt` to 0.
    - Go to RUN.
  - RUN, once per cycle:
    - If `b_reg[0]`: `acc <= acc + a_reg`, computed at 2*OP_W bits with no overflow possible.
    - `a_reg <<= 1`, `b_reg >>= 1`, `cnt++`.
    - When `cnt == OP_W-1`:
      - Load `ip_data_out` with the final accumulated value, including this cycle's add.
      - Assert `done_pulse`.
      - Go to IDLE.
- `status_busy` = (state != IDLE), registered or decoded from the state register with no combinational input path.
- Abort: `ctrl_enable` == 0 in LOAD or RUN.
  - Next state is IDLE.
  - `ip_data_out` keeps its previous value.
  - No `done_pulse`.
  - Abort has priority over completion in the same cycle.
- `start` cannot occur in LOAD/RUN: a new edge requires a fall first, which aborts.
- `data_in` changes after the LOAD capture do not affect the running multiply.
- `ip_data_out` changes only on completion.

## Timing
- Reset (async assert): state IDLE, `en_q`=0, `status_busy`=0, `ip_data_out`=0, `done_pulse`=0, internal registers 0.
- Release of `rst` while `ctrl_enable`=1 yields a start on the first edge (`en_q` resets to 0).
- Edge T0 samples `start`; state becomes LOAD and `status_busy` rises after T0.
- Edge T1 captures operands from `data_in`.
- Edges T2..T(OP_W+1) are RUN.
  - At T(OP_W+1), `ip_data_out` is updated, `done_pulse` is high for the following cycle, and `status_busy` falls.
- Busy duration is OP_W+1 cycles; 17 at the default.
- Reset asserted mid-operation: immediate return to the reset values above.

## Test plan
- OP_W=16:
  - Set `data_in`=0x0003_0005, raise `ctrl_enable`.
  - Require `status_busy` high for exactly 17 cycles.
  - Require `ip_data_out`=0x0000_000F and a single `done_pulse` in the cycle busy falls.
- `data_in`=0xFFFF_FFFF → `ip_data_out`=0xFFFE_0001.
- `data_in`=0x0000_1234 → `ip_data_out`=0x0000_0000 (B=0; full 17-cycle busy still required).
- Abort:
  - After a 3×5 multiply, start 0x0002_0007 and drop `ctrl_enable` at RUN cycle 5.
  - Require busy low on the next cycle, `ip_data_out` still 0x0000_000F, and no `done_pulse`.
- Hold `ctrl_enable` high after completion → no restart; `status_busy` stays 0.
  - Toggle 0→1 → a new multiply runs.
  - Changing `data_in` mid-RUN does not alter the result.
- Assert `rst` mid-RUN:
  - All outputs go to 0 asynchronously.
  - After release with `ctrl_enable`=1, a multiply starts on the first clock edge.
